// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer: FSM state encoding,
// result status codes and the default cycle-counter width.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_TIMEOUT = 2'b01;
  localparam status_t ST_ABORT   = 2'b10;

  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/run_cycle_counter.sv
// Execution-cycle counter: synchronous clear, counts while enabled and
// saturates once it reaches the supplied limit.
module run_cycle_counter
  import run_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  assign at_limit = (count == limit);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Host-side run controller: pulses CoreStart, times the run until CoreAck,
// and reports ok / timeout / abort together with the RUN cycle count.
//
// state | meaning
// IDLE  | waiting for RunReq; captures ProgSel and clears the count on accept
// START | one settle cycle, then CoreStart high for START_CYC cycles
// RUN   | counting cycles; Ack masked in the first cycle
// DONE  | result valid; waits for RunReq to drop
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int START_CYC = 2,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = 50000,
  parameter int NPROG_W   = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               RunReq,
  input  logic [NPROG_W-1:0] ProgSel,
  input  logic               RunAbort,
  input  logic               CoreAck,
  output logic               CoreStart,
  output logic [NPROG_W-1:0] CoreProgSel,
  output logic               Busy,
  output logic               RunDone,
  output logic [1:0]         RunStatus,
  output logic [CNT_W-1:0]   CycleCount,
  output logic [7:0]         RunCount
);

  run_state_t state;
  logic [3:0] startCnt;
  logic       firstRun;
  logic       cntClear;
  logic       cntEnable;
  logic       atLimit;

  assign cntClear  = (state == IDLE) && RunReq;
  assign cntEnable = (state == RUN);

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .clear    (cntClear),
    .enable   (cntEnable),
    .limit    (CNT_W'(TIMEOUT)),
    .count    (CycleCount),
    .at_limit (atLimit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      startCnt    <= '0;
      firstRun    <= 1'b0;
      CoreStart   <= 1'b0;
      CoreProgSel <= '0;
      Busy        <= 1'b0;
      RunDone     <= 1'b0;
      RunStatus   <= ST_OK;
      RunCount    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (RunReq) begin
            state       <= START;
            CoreProgSel <= ProgSel;
            startCnt    <= 4'(START_CYC);
            Busy        <= 1'b1;
          end
        end
        START: begin
          if (RunAbort) begin
            state     <= DONE;
            CoreStart <= 1'b0;
            Busy      <= 1'b0;
            RunDone   <= 1'b1;
            RunStatus <= ST_ABORT;
          end else if (startCnt != 4'd0) begin
            CoreStart <= 1'b1;
            startCnt  <= startCnt - 4'd1;
          end else begin
            CoreStart <= 1'b0;
            firstRun  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          firstRun <= 1'b0;
          // firstRun hides an Ack still high from the previous program
          if (RunAbort) begin
            state     <= DONE;
            Busy      <= 1'b0;
            RunDone   <= 1'b1;
            RunStatus <= ST_ABORT;
          end else if (CoreAck && !firstRun) begin
            state     <= DONE;
            Busy      <= 1'b0;
            RunDone   <= 1'b1;
            RunStatus <= ST_OK;
            RunCount  <= RunCount + 8'd1;
          end else if (atLimit) begin
            state     <= DONE;
            Busy      <= 1'b0;
            RunDone   <= 1'b1;
            RunStatus <= ST_TIMEOUT;
          end
        end
        DONE: begin
          if (!RunReq) begin
            state   <= IDLE;
            RunDone <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: a reference model pushes expected run
// results to a scoreboard queue, popped and checked when RunDone rises.
module tb_run_sequencer;

  localparam int START_CYC = 2;
  localparam int CNT_W     = 16;
  localparam int TIMEOUT   = 20;
  localparam int NPROG_W   = 2;

  logic               Clk;
  logic               Reset_n;
  logic               RunReq;
  logic [NPROG_W-1:0] ProgSel;
  logic               RunAbort;
  logic               CoreAck;
  logic               CoreStart;
  logic [NPROG_W-1:0] CoreProgSel;
  logic               Busy;
  logic               RunDone;
  logic [1:0]         RunStatus;
  logic [CNT_W-1:0]   CycleCount;
  logic [7:0]         RunCount;

  run_sequencer #(
    .START_CYC (START_CYC),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .NPROG_W   (NPROG_W)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .RunReq      (RunReq),
    .ProgSel     (ProgSel),
    .RunAbort    (RunAbort),
    .CoreAck     (CoreAck),
    .CoreStart   (CoreStart),
    .CoreProgSel (CoreProgSel),
    .Busy        (Busy),
    .RunDone     (RunDone),
    .RunStatus   (RunStatus),
    .CycleCount  (CycleCount),
    .RunCount    (RunCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [1:0] status;
    int         count;
    int         prog;
    logic [7:0] rc;
    int         doneJ;
    int         csHigh;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] expRc = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs driven at negedge index j are sampled at accept-edge + j + 1.
  // RUN edge k (k>=1) therefore samples inputs driven at j = START_CYC + k.
  function automatic exp_t model(input int prog, input int ackJ, input int abortJ,
                                 input logic [7:0] rcIn);
    exp_t e;
    e.prog   = prog;
    e.status = 2'b00;
    e.count  = 0;
    e.rc     = rcIn;
    e.doneJ  = -1;
    if (abortJ >= 0 && abortJ <= START_CYC) begin
      e.status = 2'b10;
      e.doneJ  = abortJ + 1;
    end else begin
      for (int k = 1; k <= TIMEOUT + 1; k++) begin
        int j;
        j = START_CYC + k;
        if (abortJ == j) begin
          e.status = 2'b10;
          e.count  = (k < TIMEOUT) ? k : TIMEOUT;
          e.doneJ  = j + 1;
          break;
        end else if (k >= 2 && ackJ >= 0 && j >= ackJ) begin
          e.status = 2'b00;
          e.count  = (k < TIMEOUT) ? k : TIMEOUT;
          e.doneJ  = j + 1;
          e.rc     = rcIn + 8'd1;
          break;
        end else if (k - 1 == TIMEOUT) begin
          e.status = 2'b01;
          e.count  = TIMEOUT;
          e.doneJ  = j + 1;
          break;
        end
      end
    end
    e.csHigh = (e.doneJ - 1 < START_CYC) ? e.doneJ - 1 : START_CYC;
    return e;
  endfunction

  task automatic doRun(input string tag, input int prog, input int ackJ,
                       input int abortJ, input int newProgJ);
    exp_t e;
    int   doneJ;
    int   cs;
    sb.push_back(model(prog, ackJ, abortJ, expRc));
    expRc   = sb[$].rc;
    ProgSel = NPROG_W'(prog);
    RunReq  = 1'b1;
    doneJ   = -1;
    cs      = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge Clk);
      if (RunDone) begin
        doneJ = j;
        break;
      end
      if (CoreStart) cs++;
      if (j == 0) begin
        chk({tag, ":clear"}, 32'(CycleCount), 32'd0);
        chk({tag, ":busy"}, 32'(Busy), 32'd1);
      end
      if (j == newProgJ) ProgSel = NPROG_W'(prog ^ 3);
      CoreAck  = (ackJ >= 0 && j >= ackJ);
      RunAbort = (j == abortJ);
    end
    CoreAck  = 1'b0;
    RunAbort = 1'b0;
    e = sb.pop_front();
    chk({tag, ":latency"}, 32'(doneJ), 32'(e.doneJ));
    chk({tag, ":startcyc"}, 32'(cs), 32'(e.csHigh));
    chk({tag, ":status"}, 32'(RunStatus), 32'(e.status));
    chk({tag, ":count"}, 32'(CycleCount), 32'(e.count));
    chk({tag, ":prog"}, 32'(CoreProgSel), 32'(e.prog));
    chk({tag, ":runcount"}, 32'(RunCount), 32'(e.rc));
    chk({tag, ":busyoff"}, 32'(Busy), 32'd0);
    chk({tag, ":startoff"}, 32'(CoreStart), 32'd0);
  endtask

  task automatic releaseReq(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk("hold:done", 32'(RunDone), 32'd1);
      chk("hold:busy", 32'(Busy), 32'd0);
      chk("hold:start", 32'(CoreStart), 32'd0);
    end
    RunReq = 1'b0;
    @(negedge Clk);
    chk("idle:done", 32'(RunDone), 32'd0);
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, ":CoreStart"}, 32'(CoreStart), 32'd0);
    chk({tag, ":CoreProgSel"}, 32'(CoreProgSel), 32'd0);
    chk({tag, ":Busy"}, 32'(Busy), 32'd0);
    chk({tag, ":RunDone"}, 32'(RunDone), 32'd0);
    chk({tag, ":RunStatus"}, 32'(RunStatus), 32'd0);
    chk({tag, ":CycleCount"}, 32'(CycleCount), 32'd0);
    chk({tag, ":RunCount"}, 32'(RunCount), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    Reset_n  = 1'b0;
    RunReq   = 1'b0;
    ProgSel  = '0;
    RunAbort = 1'b0;
    CoreAck  = 1'b0;
    #1;
    chkResetVals("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chkResetVals("postreset");

    // normal run, ProgSel changed mid-run must not leak through
    doRun("normal", 2, 12, -1, 5);
    releaseReq(0);
    // Ack high from the start: masked in the first RUN cycle
    doRun("stale", 1, 0, -1, -1);
    releaseReq(0);
    doRun("timeout", 3, -1, -1, -1);
    releaseReq(0);
    doRun("abort", 0, -1, 7, -1);
    releaseReq(0);
    doRun("abortack", 2, 7, 7, -1);
    releaseReq(0);
    doRun("startabort", 1, -1, 1, -1);
    releaseReq(0);
    // RunAbort while idle does nothing
    RunAbort = 1'b1;
    @(negedge Clk);
    RunAbort = 1'b0;
    chk("idleabort:done", 32'(RunDone), 32'd0);
    chk("idleabort:busy", 32'(Busy), 32'd0);

    doRun("hs1", 2, 5, -1, -1);
    releaseReq(4);
    doRun("hs2", 1, 6, -1, -1);
    releaseReq(0);

    n = 256 - int'(expRc);
    for (int i = 0; i < n; i++) begin
      doRun("wrap", i % 4, 0, -1, -1);
      releaseReq(0);
    end
    chk("wrap:final", 32'(RunCount), 32'd0);
    doRun("afterwrap", 3, 0, -1, -1);
    releaseReq(0);

    // async reset while CoreStart is high, between clock edges
    ProgSel = 2'd3;
    RunReq  = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("midstart:CoreStart", 32'(CoreStart), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chkResetVals("asyncreset");
    RunReq = 1'b0;
    #4;
    Reset_n = 1'b1;
    expRc = 8'd0;
    @(negedge Clk);
    chkResetVals("afterasync");
    doRun("afterasyncrun", 2, 8, -1, -1);
    releaseReq(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Host-side controller that sequences program runs on the single-cycle core. It accepts a run request with a program select, pulses the core's Start for a fixed number of cycles, then counts execution cycles until the core raises its done flag (Ack). It reports the result as completed, timed-out or aborted, with the cycle count. It sits between the testbench/host and the processor top level, and is the only driver of the core's Start input.

Parameters:
START_CYC, 2, number of cycles CoreStart is held high per run (legal range 1..15)
CNT_W, 16, width of the execution cycle counter
TIMEOUT, 50000, RUN-state cycle limit before a run is declared timed out (must be < 2**CNT_W)
NPROG_W, 2, width of the program select

Ports:
Clk  input  1  clock, posedge only
Reset_n  input  1  asynchronous reset, active-low
RunReq  input  1  level request from host; sampled in IDLE
ProgSel  input  NPROG_W  program index; captured on request acceptance
RunAbort  input  1  host abort; effective in START and RUN
CoreAck  input  1  done flag from the core
CoreStart  output  1  start/reset pulse to the core
CoreProgSel  output  NPROG_W  latched program index to the core
Busy  output  1  high in START and RUN
RunDone  output  1  high in DONE; result outputs valid
RunStatus  output  2  00 ok, 01 timeout, 10 aborted, 11 unused
CycleCount  output  CNT_W  RUN cycles counted for the last run
RunCount  output  8  number of runs that completed with status ok

Behaviour:
- States: IDLE, START, RUN, DONE. Encoding comes from the package.
- Reset (Reset_n low, asynchronous): state IDLE, CoreStart 0, CoreProgSel 0, Busy 0, RunDone 0, RunStatus 00, CycleCount 0, RunCount 0, start-phase counter 0.
- IDLE:
  - When RunReq=1, capture ProgSel into CoreProgSel, clear CycleCount, and go to START on the next edge.
  - RunReq=0 means stay in IDLE.
- START:
  - CoreStart=1 for exactly START_CYC consecutive cycles, then go to RUN.
  - CoreAck is ignored in this state.
  - RunAbort=1 goes to DONE with status 10, and CoreStart drops on the same edge.
- RUN:
  - CoreStart=0. CycleCount increments by 1 every RUN cycle.
  - CoreAck is ignored in the first RUN cycle, which masks a stale Ack left over from the previous program.
  - CoreAck=1 in any later RUN cycle goes to DONE with status 00 and increments RunCount (8-bit wrap, FF->00). The Ack cycle itself is counted.
  - When CycleCount == TIMEOUT and CoreAck=0, go to DONE with status 01. CycleCount holds at TIMEOUT.
  - Priority within one cycle: RunAbort > CoreAck > timeout.
- DONE:
  - RunDone=1. RunStatus, CycleCount and CoreProgSel are held stable.
  - When RunReq=0, go to IDLE. While RunReq stays 1, remain in DONE; a new run requires RunReq to drop and rise again.
  - RunAbort in DONE or IDLE has no effect.
- Minimum latency: RunReq accepted at edge 0, CoreStart high for edges 1..START_CYC, RUN from edge START_CYC+1, earliest ok completion 2 cycles after that.
- ProgSel changes after acceptance have no effect until the next accepted request.
- All outputs are registered; none are combinational from inputs.
- Reset asserted mid-run forces IDLE immediately and drops CoreStart asynchronously.

Decomposition:
- Package run_seq_pkg holds:
  - the state enum (IDLE, START, RUN, DONE);
  - the RunStatus encodings as typed constants (ST_OK, ST_TIMEOUT, ST_ABORT);
  - the default CNT_W.
- Sub-module run_cycle_counter holds CycleCount:
  - parameterised by CNT_W;
  - inputs are clear, enable and limit;
  - outputs are count and at_limit, with saturate-at-limit behaviour.
- The FSM and the START_CYC down-counter live in run_sequencer.

Test Plan:
- Normal run: ProgSel=2, RunReq=1; CoreAck rises 10 cycles into RUN -> CoreStart high exactly 2 cycles, RunDone=1, RunStatus=00, CycleCount=10, CoreProgSel=2, RunCount=1.
- Stale Ack: CoreAck held 1 throughout START and the first RUN cycle -> no completion in the first RUN cycle; DONE on the 2nd RUN cycle with CycleCount=2, status 00.
- Timeout: TIMEOUT=20, CoreAck never rises -> DONE with status 01 and CycleCount=20; RunCount unchanged.
- Abort: RunAbort pulsed on the 5th RUN cycle -> DONE next edge, status 10, CycleCount=5; RunAbort in the same cycle as CoreAck also yields status 10.
- Handshake: RunReq held high through DONE -> stays in DONE with no restart; RunReq low then high with ProgSel=1 -> new run, CycleCount cleared, CoreProgSel=1. 256 ok runs -> RunCount wraps to 0.
- Async reset: Reset_n pulled low mid-START (between clock edges) -> CoreStart=0 and all outputs at reset values without waiting for a clock edge; after release, IDLE.
